// File: rtl/can_tx_scheduler_if.sv
// Mailbox request, transmitter handshake and bus-level signals of the CAN transmit scheduler.
// The scheduler uses the master modport. The mailbox and transmitter side uses the slave modport.
interface can_tx_scheduler_if;
  logic        i_Rx_Serial;
  logic [3:0]  i_Req;
  logic [43:0] i_Ids;
  logic [3:0]  o_Grant;
  logic [10:0] o_Tx_Id;
  logic        o_Tx_Start;
  logic        i_Tx_Done;
  logic        i_Arb_Lost;
  logic        i_Tx_Error;
  logic [3:0]  o_Ack;
  logic [3:0]  o_Fail;
  logic        o_Busy;

  modport master (
    input  i_Rx_Serial, i_Req, i_Ids, i_Tx_Done, i_Arb_Lost, i_Tx_Error,
    output o_Grant, o_Tx_Id, o_Tx_Start, o_Ack, o_Fail, o_Busy
  );

  modport slave (
    output i_Rx_Serial, i_Req, i_Ids, i_Tx_Done, i_Arb_Lost, i_Tx_Error,
    input  o_Grant, o_Tx_Id, o_Tx_Start, o_Ack, o_Fail, o_Busy
  );
endinterface

// File: rtl/can_tx_scheduler.sv
// Four-mailbox CAN transmit scheduler. It waits for an idle bus and then grants the lowest pending ID.
// It also tracks per-mailbox retries and reports ack/fail pulses back to the mailboxes.
module can_tx_scheduler #(
  parameter int unsigned CLKS_PER_BIT = 10,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned IDLE_BITS    = 11
) (
  input logic               i_Clock,
  input logic               i_Rst_n,
  can_tx_scheduler_if.master bus
);

  localparam int unsigned IDLE_CLKS = IDLE_BITS * CLKS_PER_BIT;
  localparam int unsigned CNT_W     = $clog2(IDLE_CLKS + 1);

  typedef enum logic [1:0] {BUS_WAIT, SELECT, START, ACTIVE} state_t;

  state_t           state;
  logic [1:0]       rx_sync;
  logic [CNT_W-1:0] idle_cnt;
  logic             bus_idle;
  logic [3:0]       mask;
  logic [3:0]       eligible;
  logic [1:0]       retry [4];
  logic [1:0]       grant_idx;
  logic             sel_found;
  logic [1:0]       sel_idx;
  logic [10:0]      sel_id;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) rx_sync <= 2'b11;
    else          rx_sync <= {rx_sync[0], bus.i_Rx_Serial};
  end

  assign bus_idle = (idle_cnt == CNT_W'(IDLE_CLKS));

  // Strict less-than keeps the lower mailbox index when two IDs are equal.
  always_comb begin
    eligible  = bus.i_Req & ~mask;
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_id    = '0;
    for (int k = 0; k < 4; k++) begin
      if (eligible[k] && (!sel_found || (bus.i_Ids[11*k +: 11] < sel_id))) begin
        sel_found = 1'b1;
        sel_idx   = 2'(k);
        sel_id    = bus.i_Ids[11*k +: 11];
      end
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state          <= BUS_WAIT;
      bus.o_Grant    <= '0;
      bus.o_Tx_Id    <= '0;
      bus.o_Tx_Start <= 1'b0;
      bus.o_Ack      <= '0;
      bus.o_Fail     <= '0;
      bus.o_Busy     <= 1'b0;
      idle_cnt       <= '0;
      mask           <= '0;
      grant_idx      <= '0;
      for (int k = 0; k < 4; k++) retry[k] <= '0;
    end else begin
      bus.o_Tx_Start <= 1'b0;
      bus.o_Ack      <= '0;
      bus.o_Fail     <= '0;
      mask           <= (mask | bus.o_Ack | bus.o_Fail) & bus.i_Req;

      if (!rx_sync[1])    idle_cnt <= '0;
      else if (!bus_idle) idle_cnt <= idle_cnt + CNT_W'(1);

      case (state)
        BUS_WAIT: begin
          if (bus_idle && (|eligible)) begin
            state      <= SELECT;
            bus.o_Busy <= 1'b1;
          end
        end
        SELECT: begin
          if (sel_found) begin
            bus.o_Grant    <= 4'b0001 << sel_idx;
            bus.o_Tx_Id    <= sel_id;
            grant_idx      <= sel_idx;
            bus.o_Tx_Start <= 1'b1;
            state          <= START;
          end else begin
            state      <= BUS_WAIT;
            bus.o_Busy <= 1'b0;
            idle_cnt   <= '0;
          end
        end
        START: state <= ACTIVE;
        ACTIVE: begin
          // Any result ends the attempt; the idle count restarts so the next attempt waits a full idle period.
          if (bus.i_Tx_Error || bus.i_Arb_Lost || bus.i_Tx_Done) begin
            state       <= BUS_WAIT;
            bus.o_Grant <= '0;
            bus.o_Busy  <= 1'b0;
            idle_cnt    <= '0;
          end
          if (bus.i_Tx_Error) begin
            if (({1'b0, retry[grant_idx]} + 3'd1) == 3'(MAX_RETRY)) begin
              bus.o_Fail       <= bus.o_Grant;
              retry[grant_idx] <= '0;
            end else begin
              retry[grant_idx] <= retry[grant_idx] + 2'd1;
            end
          end else if (!bus.i_Arb_Lost && bus.i_Tx_Done) begin
            bus.o_Ack        <= bus.o_Grant;
            retry[grant_idx] <= '0;
          end
        end
        default: state <= BUS_WAIT;
      endcase

      for (int k = 0; k < 4; k++) begin
        if (!bus.i_Req[k]) retry[k] <= '0;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Scoreboard bench for can_tx_scheduler. The stimulus pushes the expected start/ack/fail events with their cycle stamps.
// A negedge monitor pops these expected events and compares them with every event the DUT shows.
module tb_can_tx_scheduler;

  typedef struct {
    logic        start;
    logic [3:0]  grant;
    logic [10:0] id;
    logic [3:0]  ack;
    logic [3:0]  fail;
    int          cyc;
  } exp_t;

  logic i_Clock = 1'b0;
  logic i_Rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  can_tx_scheduler_if bus();

  can_tx_scheduler #(.CLKS_PER_BIT(10), .MAX_RETRY(3), .IDLE_BITS(11)) dut (
    .i_Clock(i_Clock),
    .i_Rst_n(i_Rst_n),
    .bus    (bus)
  );

  always #5 i_Clock = ~i_Clock;
  always @(posedge i_Clock) cyc <= cyc + 1;

  function automatic void pushExp(input logic start, input logic [3:0] grant, input logic [10:0] id,
                                  input logic [3:0] ack, input logic [3:0] fail, input int c);
    exp_t e;
    e.start = start; e.grant = grant; e.id = id; e.ack = ack; e.fail = fail; e.cyc = c;
    exp_q.push_back(e);
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s got=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] req, input logic [43:0] ids);
    @(negedge i_Clock);
    bus.i_Req = req;
    bus.i_Ids = ids;
  endtask

  // Returns at the negedge after o_Tx_Start, with the DUT in ACTIVE.
  task automatic waitActive(input int bound);
    int n = 0;
    do begin
      @(negedge i_Clock);
      n++;
    end while (!bus.o_Tx_Start && n < bound);
    if (!bus.o_Tx_Start) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL start_timeout got=no o_Tx_Start within %0d cycles required=o_Tx_Start", bound);
    end
    @(negedge i_Clock);
  endtask

  task automatic pulse(input logic done, input logic arb, input logic err);
    bus.i_Tx_Done  = done;
    bus.i_Arb_Lost = arb;
    bus.i_Tx_Error = err;
    @(negedge i_Clock);
    bus.i_Tx_Done  = 1'b0;
    bus.i_Arb_Lost = 1'b0;
    bus.i_Tx_Error = 1'b0;
  endtask

  always @(negedge i_Clock) begin
    exp_t e;
    logic ok;
    if (bus.o_Tx_Start || (|bus.o_Ack) || (|bus.o_Fail)) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_event cyc=%0d got start=%b grant=%b id=%h ack=%b fail=%b required=no event",
                 cyc, bus.o_Tx_Start, bus.o_Grant, bus.o_Tx_Id, bus.o_Ack, bus.o_Fail);
      end else begin
        e  = exp_q.pop_front();
        ok = (e.start == bus.o_Tx_Start) && (e.grant == bus.o_Grant) && (e.ack == bus.o_Ack) &&
             (e.fail == bus.o_Fail) && (e.cyc == cyc) && (!e.start || (e.id == bus.o_Tx_Id));
        if (!ok) begin
          miscompares++;
          $display("[TB] FAIL event got cyc=%0d start=%b grant=%b id=%h ack=%b fail=%b required cyc=%0d start=%b grant=%b id=%h ack=%b fail=%b",
                   cyc, bus.o_Tx_Start, bus.o_Grant, bus.o_Tx_Id, bus.o_Ack, bus.o_Fail,
                   e.cyc, e.start, e.grant, e.id, e.ack, e.fail);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog got=simulation still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int p, c;
    logic [43:0] ids1, ids2, ids3, ids4;
    ids1 = {11'h000, 11'h000, 11'h000, 11'h123};
    ids2 = {11'h7FF, 11'h050, 11'h050, 11'h300};
    ids3 = {11'h7FF, 11'h111, 11'h050, 11'h300};
    ids4 = {11'h7FF, 11'h111, 11'h050, 11'h123};

    bus.i_Rx_Serial = 1'b1;
    bus.i_Req       = '0;
    bus.i_Ids       = '0;
    bus.i_Tx_Done   = 1'b0;
    bus.i_Arb_Lost  = 1'b0;
    bus.i_Tx_Error  = 1'b0;
    i_Rst_n         = 1'b0;

    repeat (3) @(negedge i_Clock);
    checkOutput("reset_grant", 16'(bus.o_Grant), 16'h0);
    checkOutput("reset_tx_id", 16'(bus.o_Tx_Id), 16'h0);
    checkOutput("reset_start", 16'(bus.o_Tx_Start), 16'h0);
    checkOutput("reset_ack", 16'(bus.o_Ack), 16'h0);
    checkOutput("reset_fail", 16'(bus.o_Fail), 16'h0);
    checkOutput("reset_busy", 16'(bus.o_Busy), 16'h0);

    // Single request from reset: start 112 clocks later.
    @(negedge i_Clock);
    i_Rst_n   = 1'b1;
    bus.i_Req = 4'b0001;
    bus.i_Ids = ids1;
    c = cyc;
    pushExp(1'b1, 4'b0001, 11'h123, 4'b0, 4'b0, c + 112);
    waitActive(300);
    checkOutput("busy_active", 16'(bus.o_Busy), 16'h1);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b0001, 4'b0, p + 1);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (130) @(negedge i_Clock);

    // Priority by lowest ID and then lowest index, and arbitration loss together with done.
    applyStimulus(4'b0000, ids2);
    applyStimulus(4'b1111, ids2);
    c = cyc;
    pushExp(1'b1, 4'b0010, 11'h050, 4'b0, 4'b0, c + 2);
    waitActive(300);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b0010, 4'b0, p + 1);
    pushExp(1'b1, 4'b0100, 11'h050, 4'b0, 4'b0, p + 113);
    pulse(1'b1, 1'b0, 1'b0);
    waitActive(300);
    p = cyc;
    pushExp(1'b1, 4'b0100, 11'h050, 4'b0, 4'b0, p + 113);
    pulse(1'b1, 1'b1, 1'b0);
    waitActive(300);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b0100, 4'b0, p + 1);
    pushExp(1'b1, 4'b0001, 11'h300, 4'b0, 4'b0, p + 113);
    pulse(1'b1, 1'b0, 1'b0);
    waitActive(300);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b0001, 4'b0, p + 1);
    pushExp(1'b1, 4'b1000, 11'h7FF, 4'b0, 4'b0, p + 113);
    pulse(1'b1, 1'b0, 1'b0);
    waitActive(300);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b1000, 4'b0, p + 1);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (130) @(negedge i_Clock);

    // Retry exhaustion on mailbox 2. Arbitration loss does not count as a retry, and an error overrides done.
    applyStimulus(4'b0000, ids3);
    applyStimulus(4'b0100, ids3);
    c = cyc;
    pushExp(1'b1, 4'b0100, 11'h111, 4'b0, 4'b0, c + 2);
    waitActive(300);
    p = cyc;
    pushExp(1'b1, 4'b0100, 11'h111, 4'b0, 4'b0, p + 113);
    pulse(1'b0, 1'b0, 1'b1);
    waitActive(300);
    p = cyc;
    pushExp(1'b1, 4'b0100, 11'h111, 4'b0, 4'b0, p + 113);
    pulse(1'b1, 1'b1, 1'b0);
    waitActive(300);
    p = cyc;
    pushExp(1'b1, 4'b0100, 11'h111, 4'b0, 4'b0, p + 113);
    pulse(1'b1, 1'b0, 1'b1);
    waitActive(300);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b0, 4'b0100, p + 1);
    pulse(1'b0, 1'b0, 1'b1);
    repeat (150) @(negedge i_Clock);
    pulse(1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge i_Clock);

    // Request dropped while ACTIVE, then a one-clock dominant glitch at idle count 100.
    applyStimulus(4'b0000, ids4);
    applyStimulus(4'b1000, ids4);
    c = cyc;
    pushExp(1'b1, 4'b1000, 11'h7FF, 4'b0, 4'b0, c + 2);
    waitActive(300);
    bus.i_Req = 4'b0001;
    @(negedge i_Clock);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b1000, 4'b0, p + 1);
    pushExp(1'b1, 4'b0001, 11'h123, 4'b0, 4'b0, p + 216);
    pulse(1'b1, 1'b0, 1'b0);
    while (cyc < p + 101) @(negedge i_Clock);
    bus.i_Rx_Serial = 1'b0;
    @(negedge i_Clock);
    bus.i_Rx_Serial = 1'b1;
    waitActive(300);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b0001, 4'b0, p + 1);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (130) @(negedge i_Clock);

    // Reset in the middle of a transmission.
    applyStimulus(4'b0000, ids4);
    applyStimulus(4'b0010, ids4);
    c = cyc;
    pushExp(1'b1, 4'b0010, 11'h050, 4'b0, 4'b0, c + 2);
    waitActive(300);
    i_Rst_n = 1'b0;
    #1;
    checkOutput("grant_on_reset", 16'(bus.o_Grant), 16'h0);
    checkOutput("busy_on_reset", 16'(bus.o_Busy), 16'h0);
    bus.i_Tx_Done = 1'b1;
    @(negedge i_Clock);
    bus.i_Tx_Done = 1'b0;
    @(negedge i_Clock);
    i_Rst_n = 1'b1;
    c = cyc;
    pushExp(1'b1, 4'b0010, 11'h050, 4'b0, 4'b0, c + 112);
    waitActive(300);
    p = cyc;
    pushExp(1'b0, 4'b0, 11'h0, 4'b0010, 4'b0, p + 1);
    pulse(1'b1, 1'b0, 1'b0);
    repeat (130) @(negedge i_Clock);

    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vectors++;
      miscompares++;
      $display("[TB] FAIL missing_event got=none required cyc=%0d start=%b grant=%b ack=%b fail=%b",
               e.cyc, e.start, e.grant, e.ack, e.fail);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
